vc_multi_drop_unit: RTL
=======================

# vc_multi_drop_unit

Parametrised successor to the single-shot drop unit: sits on a val/rdy response channel (typically memory response into a pipelined core) and discards up to p_max_drops future packets requested by squashes. Each drop pulse either kills the packet handshaking in the same cycle or is queued as a pending drop. Queued drops consume subsequent arriving packets in order. Messages pass through combinationally; the only state is a pending-drop counter plus optional statistics.

## Interface

Parameters:
- p_msg_nbits, 1, message width
- p_max_drops, 4, max queued drops (≥1); c_cnt_nbits = $clog2(p_max_drops+1)

Ports:
- clk  in  1  clock, label L
- reset  in  1  synchronous, active-high; label L
- drop  in  1  request to drop next arriving packet; Domain sd
- drop_rdy  out  1  drop accepted this cycle when high; Domain sd
- in_msg  in  p_msg_nbits  input message; Domain sd
- in_val  in  1  input valid; Domain sd
- in_rdy  out  1  input ready; Domain sd
- out_msg  out  p_msg_nbits  equals in_msg; Domain sd
- out_val  out  1  output valid; Domain sd
- out_rdy  in  1  output ready; Domain sd
- drop_pend  out  c_cnt_nbits  current pending-drop count; Domain sd
- sd  in  1  security domain select, label L
- num_dropped  out  32  packets discarded (only with VC_DROPUNIT_STATS_EN); Domain sd

## Operation

- State: cnt (0..p_max_drops), exposed as drop_pend. in_go = in_val && in_rdy.
- cnt == 0 (pass): out_val = in_val && !drop; in_rdy = out_rdy. Same-cycle drop && in_go kills that packet, cnt unchanged. drop && !in_go: cnt+1.
- cnt > 0 (drain): out_val = 0; in_rdy = 1; every arriving packet discarded. next cnt = cnt − in_val + (drop && drop_rdy).
- drop_rdy = !reset && (cnt != p_max_drops). drop while drop_rdy low is ignored; upstream must hold drop until accepted.
- Simultaneous drop and discard at cnt == p_max_drops: drop ignored, cnt − 1 (drop_rdy is combinationally low).
- Simultaneous drop and discard at 0 < cnt < max: cnt unchanged.
- Counter never wraps; no overflow or underflow possible under the rules above.
- out_msg = in_msg always.

## Timing

- Zero-latency combinational pass-through; no message buffering.
- Reset: cnt ← 0 next edge. While reset high: out_val = 0, in_rdy = 0, drop_rdy = 0, drop ignored. Reset mid-drain clears all pending drops; first post-reset packet passes.
- All state updates occur at posedge clk; every output is a function of cnt and current inputs only.
- A queued drop takes effect from the cycle after acceptance.

## Configuration

- VC_DROPUNIT_STATS_EN defined: adds num_dropped, a 32-bit counter, reset to 0, incremented by 1 per discarded packet (same-cycle kill or drain discard), wrapping modulo 2^32.
- Undefined: port and register absent; behaviour otherwise identical.

## Structure

- Shared include (vc-DropUnitDefs.v): c_cnt_nbits width function, stats width constant (32), localparams for pass/drain mode encodings.
- One sub-module: vc_UpDownCounter (parametrised width/max, synchronous reset, inc/dec inputs, saturation-free by contract), instantiated for cnt; stats counter inline.

## Test plan

- Pass-through: cnt 0, no drop, in_val=1, out_rdy=1, in_msg=0xA5 -> out_val=1, out_msg=0xA5, drop_pend=0.
- Same-cycle kill: drop=1, in_val=1, out_rdy=1 -> out_val=0, in_go=1, drop_pend stays 0, num_dropped +1.
- Queued drops: three drop pulses with in_val=0 -> drop_pend=3; next three packets discarded with in_rdy=1, out_val=0; fourth packet 0x3C passes.
- Saturation: p_max_drops=4, five drop cycles, no traffic -> drop_pend=4, drop_rdy=0 on fifth, drop ignored; one arrival with drop=1 -> drop_pend=3.
- Simultaneous drop and discard at cnt=2 -> drop_pend stays 2, packet discarded.
- Reset mid-drain: drop_pend=3, assert reset one cycle -> in_rdy=0 and out_val=0 during reset; drop_pend=0 after; next packet passes.

Source files
------------

// File: rtl/vc_multi_drop_unit_pkg.sv
// Shared definitions for vc_multi_drop_unit: counter width helper, stats width, mode encodings.
package vc_multi_drop_unit_pkg;

    localparam int unsigned c_stats_nbits = 32;

    typedef enum logic {
        ModePass  = 1'b0,
        ModeDrain = 1'b1
    } mode_e;

    function automatic int unsigned cnt_nbits(input int unsigned max_drops);
        return $clog2(max_drops + 1);
    endfunction

endpackage

// File: rtl/vc_multi_drop_unit_updown.sv
// Up/down counter with synchronous active-high reset; simultaneous inc and dec cancel.
module vc_multi_drop_unit_updown #(
    parameter int unsigned p_nbits = 3,
    parameter int unsigned p_max   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [p_nbits-1:0] count
);

    logic [p_nbits-1:0] cnt_q, cnt_d;

    // Callers never over/underflow; the bounds checks just keep the counter in range regardless.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && (cnt_q != p_nbits'(p_max))) begin
            cnt_d = cnt_q + p_nbits'(1);
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - p_nbits'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/vc_multi_drop_unit.sv
// Multi-drop unit: discards up to p_max_drops future packets on a val/rdy channel.
// Optional VC_DROPUNIT_STATS_EN adds the 32-bit num_dropped counter.
module vc_multi_drop_unit
    import vc_multi_drop_unit_pkg::*;
#(
    parameter int unsigned p_msg_nbits = 1,
    parameter int unsigned p_max_drops = 4,
    localparam int unsigned c_cnt_nbits = cnt_nbits(p_max_drops)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   drop,
    output logic                   drop_rdy,
    input  logic [p_msg_nbits-1:0] in_msg,
    input  logic                   in_val,
    output logic                   in_rdy,
    output logic [p_msg_nbits-1:0] out_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    input  logic                   sd,
    output logic [c_cnt_nbits-1:0] drop_pend
`ifdef VC_DROPUNIT_STATS_EN
    ,
    output logic [c_stats_nbits-1:0] num_dropped
`endif
);

    logic [c_cnt_nbits-1:0] cnt;
    logic                   cnt_inc;
    logic                   cnt_dec;
    logic                   discard;
    mode_e                  mode;

    // sd only labels the domain of the other signals; no logic depends on it.
    logic unused_sd;
    assign unused_sd = sd;

    assign mode      = (cnt == '0) ? ModePass : ModeDrain;
    assign out_msg   = in_msg;
    assign drop_pend = cnt;

    always_comb begin
        out_val  = 1'b0;
        in_rdy   = 1'b0;
        drop_rdy = 1'b0;
        cnt_inc  = 1'b0;
        cnt_dec  = 1'b0;
        discard  = 1'b0;
        if (!reset) begin
            drop_rdy = (cnt != c_cnt_nbits'(p_max_drops));
            unique case (mode)
                ModePass: begin
                    in_rdy  = out_rdy;
                    out_val = in_val && !drop;
                    // A drop coinciding with a handshake kills that packet instead of queueing.
                    discard = drop && in_val && out_rdy;
                    cnt_inc = drop && drop_rdy && !(in_val && out_rdy);
                end
                ModeDrain: begin
                    in_rdy  = 1'b1;
                    discard = in_val;
                    cnt_dec = in_val;
                    cnt_inc = drop && drop_rdy;
                end
                default: ;
            endcase
        end
    end

    vc_multi_drop_unit_updown #(
        .p_nbits (c_cnt_nbits),
        .p_max   (p_max_drops)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .dec   (cnt_dec),
        .count (cnt)
    );

`ifdef VC_DROPUNIT_STATS_EN
    logic [c_stats_nbits-1:0] num_dropped_q, num_dropped_d;

    always_comb begin
        num_dropped_d = num_dropped_q + c_stats_nbits'(discard);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            num_dropped_q <= '0;
        end else begin
            num_dropped_q <= num_dropped_d;
        end
    end

    assign num_dropped = num_dropped_q;
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

endmodule
